// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains an exact number of words from a synchronous FIFO
// into a valid/ready stream. A 2-entry output buffer hides the FIFO's one-cycle
// read latency, so reads are issued only when a buffer slot is guaranteed.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  empty,
    output logic                  rd_en,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  issue_left_q, issue_left_d;
    logic [LEN_WIDTH-1:0]  deliver_left_q, deliver_left_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic [DATA_WIDTH-1:0] buf_d [2];
    logic                  head_q, head_d;
    logic                  tail_q, tail_d;
    logic [1:0]            buf_cnt_q, buf_cnt_d;
    logic                  pop;
    logic                  push;
    logic [2:0]            occ_after_pop;

    // Outputs and read issue, derived only from registered state plus empty/out_ready
    always_comb begin
        out_valid     = (buf_cnt_q != 2'd0);
        out_data      = out_valid ? buf_q[head_q] : '0;
        out_last      = out_valid && (deliver_left_q == LEN_WIDTH'(1));
        busy          = (state_q != IDLE);
        done          = (state_q == DONE);
        pop           = out_valid && out_ready;
        push          = inflight_q;
        // slots that will be committed after this cycle's pop; a read issued
        // now lands next cycle, so it needs one of them to be free
        occ_after_pop = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
        rd_en         = (state_q == RUN) && !empty && (issue_left_q != '0) &&
                        (occ_after_pop < 3'd2);
    end

    // Next-state: FSM, counters and output buffer bookkeeping
    always_comb begin
        state_d        = state_q;
        issue_left_d   = issue_left_q;
        deliver_left_d = deliver_left_q;
        head_d         = head_q;
        tail_d         = tail_q;
        buf_cnt_d      = buf_cnt_q;
        buf_d          = buf_q;
        inflight_d     = rd_en;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d        = RUN;
                        issue_left_d   = length;
                        deliver_left_d = length;
                    end
                end
            end
            RUN: begin
                if (rd_en) issue_left_d = issue_left_q - LEN_WIDTH'(1);
                if (pop) begin
                    deliver_left_d = deliver_left_q - LEN_WIDTH'(1);
                    if (deliver_left_q == LEN_WIDTH'(1)) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // rd_data of last cycle's read is written to the tail
        if (push) begin
            buf_d[tail_q] = rd_data;
            tail_d        = ~tail_q;
        end
        if (pop) head_d = ~head_q;

        case ({push, pop})
            2'b10:   buf_cnt_d = buf_cnt_q + 2'd1;
            2'b01:   buf_cnt_d = buf_cnt_q - 2'd1;
            default: buf_cnt_d = buf_cnt_q;
        endcase
    end

    // State registers; reset drops any buffered or in-flight data
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            issue_left_q   <= '0;
            deliver_left_q <= '0;
            inflight_q     <= 1'b0;
            head_q         <= 1'b0;
            tail_q         <= 1'b0;
            buf_cnt_q      <= 2'd0;
            buf_q[0]       <= '0;
            buf_q[1]       <= '0;
        end else begin
            state_q        <= state_d;
            issue_left_q   <= issue_left_d;
            deliver_left_q <= deliver_left_d;
            inflight_q     <= inflight_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            buf_cnt_q      <= buf_cnt_d;
            buf_q[0]       <= buf_d[0];
            buf_q[1]       <= buf_d[1];
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Testbench for fifo_stream_reader: behavioural FIFO, scoreboard queue of
// expected stream words, and a monitor tracking busy/done at transfer level.
module tb_fifo_stream_reader;

    localparam int DW = 32;
    localparam int LW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] rd_data = '0;
    logic          empty = 1'b1;
    logic          rd_en;
    logic          start = 1'b0;
    logic [LW-1:0] length = '0;
    logic          busy;
    logic          done;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_last;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] fifo[$];
    logic [DW-1:0] to_write[$];

    int total = 0;
    int bad   = 0;
    int feed_pct = 100;
    int rdy_pct  = 100;
    int rdy_mode = 0;

    // monitor's transfer-level model
    int            reads_xfer = 0;
    int            pops_xfer  = 0;
    int            m_len = 0;
    int            m_rem = 0;
    bit            m_busy = 0;
    bit            m_done = 0;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    fifo_stream_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clock(clock), .reset(reset), .rd_data(rd_data), .empty(empty),
        .rd_en(rd_en), .start(start), .length(length), .busy(busy),
        .done(done), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last)
    );

    initial forever #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // FIFO with one-cycle read latency; words trickle in from to_write
    task automatic fifo_model();
        logic do_rd;
        forever begin
            @(negedge clock);
            do_rd = rd_en;
            @(posedge clock);
            if (do_rd) begin
                if (fifo.size() != 0) rd_data <= fifo.pop_front();
                else                  rd_data <= '0;
            end
            if (to_write.size() != 0 && $urandom_range(99) < feed_pct)
                fifo.push_back(to_write.pop_front());
            empty <= (fifo.size() == 0);
        end
    endtask

    task automatic rdy_drive();
        int ph = 0;
        forever begin
            @(posedge clock);
            #1;
            if (rdy_mode == 1) begin
                out_ready = (ph % 3 == 0);
                ph++;
            end else begin
                out_ready = ($urandom_range(99) < rdy_pct);
            end
        end
    endtask

    task automatic monitor();
        exp_t e;
        bit   p;
        forever begin
            @(negedge clock);
            if (reset) begin
                m_busy = 0; m_done = 0; prev_stall = 0;
                continue;
            end
            p = out_valid && out_ready;
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            if (rd_en) chk("rd_en_while_empty", empty, 0);
            if (m_busy && !m_done) chk("outstanding_le2", (reads_xfer - pops_xfer) <= 2, 1);
            if (!m_busy || m_done) chk("valid_outside_run", out_valid, 0);
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_data);
                chk("hold_last", out_last, prev_last);
            end
            if (p) begin
                if (exp_q.size() == 0) chk("extra_word", out_data, 64'hdead);
                else begin
                    e = exp_q.pop_front();
                    chk("data", out_data, e.d);
                    chk("last", out_last, e.l);
                end
            end
            if (m_done) chk("read_count", reads_xfer, m_len);
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (rd_en) reads_xfer++;
            if (p) pops_xfer++;
            if (m_done) begin
                m_done = 0; m_busy = 0;
            end else if (!m_busy && start) begin
                m_len = int'(length); m_rem = int'(length);
                reads_xfer = 0; pops_xfer = 0;
                m_busy = 1; m_done = (length == '0);
            end else if (m_busy && p) begin
                m_rem--;
                if (m_rem == 0) m_done = 1;
            end
        end
    endtask

    task automatic finish_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    task automatic pulse_start(input int len);
        start  = 1'b1;
        length = LW'(len);
        @(posedge clock);
        #1;
        start  = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clock);
            if (done) begin
                @(posedge clock);
                #1;
                return;
            end
        end
        chk("done_timeout", 0, 1);
        finish_run();
    endtask

    task automatic queue_words(input int len);
        logic [DW-1:0] w;
        for (int i = 0; i < len; i++) begin
            w = $urandom;
            to_write.push_back(w);
            exp_q.push_back(exp_t'{d: w, l: (i == len - 1)});
        end
    endtask

    task automatic run_xfer(input int len);
        queue_words(len);
        pulse_start(len);
        wait_done(3000);
    endtask

    initial begin
        logic [DW-1:0] w;
        logic [DW-1:0] lo[$];
        fork
            fifo_model();
            rdy_drive();
            monitor();
        join_none

        // reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_rd_en", rd_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_data", out_data, 0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // length 4, preloaded 0xA0..0xA3: exact cycle timing
        for (int i = 0; i < 4; i++) begin
            w = 32'hA0 + DW'(i);
            to_write.push_back(w);
            exp_q.push_back(exp_t'{d: w, l: (i == 3)});
        end
        repeat (6) @(posedge clock);
        #1;
        start = 1'b1;
        length = 16'd4;
        for (int k = 0; k < 9; k++) begin
            @(negedge clock);
            chk($sformatf("t1_rd_en_c%0d", k), rd_en, (k >= 1 && k <= 4));
            chk($sformatf("t1_valid_c%0d", k), out_valid, (k >= 3 && k <= 6));
            chk($sformatf("t1_done_c%0d", k), done, (k == 7));
            @(posedge clock);
            #1;
            start = 1'b0;
        end

        // length 8 with out_ready 1,0,0,1,...
        rdy_mode = 1;
        run_xfer(8);
        rdy_mode = 0;

        // length 3: one word now, two more ten cycles later
        for (int i = 0; i < 3; i++) begin
            w = 32'hC0 + DW'(i);
            exp_q.push_back(exp_t'{d: w, l: (i == 2)});
        end
        to_write.push_back(32'hC0);
        repeat (3) @(posedge clock);
        #1;
        pulse_start(3);
        repeat (10) @(posedge clock);
        #1;
        to_write.push_back(32'hC1);
        to_write.push_back(32'hC2);
        wait_done(200);

        // length 0, then a start during RUN that must be ignored
        pulse_start(0);
        wait_done(5);
        queue_words(5);
        pulse_start(5);
        repeat (2) @(posedge clock);
        #1;
        pulse_start(3);
        wait_done(200);
        repeat (5) @(posedge clock);
        #1;

        // length 1, single word
        to_write.push_back(32'h55);
        exp_q.push_back(exp_t'{d: 32'h55, l: 1'b1});
        pulse_start(1);
        wait_done(50);

        // reset after 2 of 6 words delivered
        queue_words(6);
        pulse_start(6);
        for (int i = 0; i < 200 && pops_xfer < 2; i++) begin
            @(posedge clock);
            #1;
        end
        chk("pre_reset_pops", pops_xfer, 2);
        reset = 1'b1;
        #1;
        chk("mid_rst_rd_en", rd_en, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_last", out_last, 0);
        chk("mid_rst_data", out_data, 0);
        exp_q.delete();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        lo = fifo;
        foreach (to_write[i]) lo.push_back(to_write[i]);
        chk("leftover_ge2", lo.size() >= 2, 1);
        if (lo.size() >= 2) begin
            exp_q.push_back(exp_t'{d: lo[0], l: 1'b0});
            exp_q.push_back(exp_t'{d: lo[1], l: 1'b1});
        end
        pulse_start(2);
        wait_done(100);
        fifo.delete();
        to_write.delete();
        repeat (2) @(posedge clock);
        #1;

        // randomized transfers
        for (int t = 0; t < 25; t++) begin
            rdy_pct  = $urandom_range(30, 100);
            feed_pct = $urandom_range(30, 100);
            run_xfer($urandom_range(0, 12));
        end

        repeat (5) @(posedge clock);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        finish_run();
    end

endmodule
